// File: rtl/traffic_pkg.sv
// Shared types and defaults for the traffic phase controller: FSM states,
// duration-register select codes and the power-up interval lengths.
package traffic_pkg;

  typedef enum logic [1:0] {
    ST_ALLRED = 2'd0,
    ST_GREEN  = 2'd1,
    ST_YELLOW = 2'd2,
    ST_WALK   = 2'd3
  } state_e;

  typedef enum logic [1:0] {
    SEL_BASE = 2'd0,
    SEL_EXT  = 2'd1,
    SEL_YEL  = 2'd2,
    SEL_WALK = 2'd3
  } prog_sel_e;

  localparam int DEF_T_BASE = 6;
  localparam int DEF_T_EXT  = 3;
  localparam int DEF_T_YEL  = 2;
  localparam int DEF_T_WALK = 4;

  // Width of a phase index; a two-phase controller still needs one bit.
  function automatic int phase_width(input int n_ph);
    return (n_ph > 2) ? $clog2(n_ph) : 1;
  endfunction

endpackage

// File: rtl/traffic_interval_timer.sv
// Down-counting interval timer: loads a duration (0 treated as 1), counts
// down on Tick and flags expiry on the Tick that finds a count of 1.
module traffic_interval_timer
  import traffic_pkg::*;
#(
  parameter int TW = 8
) (
  input  logic          clk,
  input  logic          Reset_n,
  input  logic          load,
  input  logic [TW-1:0] value,
  input  logic          Tick,
  output logic [TW-1:0] count,
  output logic          expired
);

  assign expired = Tick && (count == TW'(1));

  // NOTE: sequential state uses non-blocking assignments so every flop
  // samples the pre-edge values of its inputs.
  always_ff @(posedge clk or negedge Reset_n) begin
    if (!Reset_n) begin
      count <= TW'(1);
    end else if (load) begin
      count <= (value == '0) ? TW'(1) : value;
    end else if (Tick && (count > TW'(1))) begin
      count <= count - TW'(1);
    end
  end

endmodule

// File: rtl/traffic_phase_ctrl.sv
// Multi-phase traffic signal controller with one-shot green extension,
// pedestrian walk service after the last phase and runtime-programmable
// interval durations.
module traffic_phase_ctrl
  import traffic_pkg::*;
#(
  parameter int  N_PH   = 2,
  parameter int  TW     = 8,
  parameter int  T_BASE = DEF_T_BASE,
  parameter int  T_EXT  = DEF_T_EXT,
  parameter int  T_YEL  = DEF_T_YEL,
  parameter int  T_WALK = DEF_T_WALK,
  localparam int PW     = phase_width(N_PH)
) (
  input  logic            clk,
  input  logic            Reset_n,
  input  logic            Tick,
  input  logic [N_PH-1:0] Sensor_Sync,
  input  logic            WR,
  input  logic            Prog_Sync,
  input  logic [1:0]      Prog_Sel,
  input  logic [TW-1:0]   Prog_Val,
  output logic [N_PH-1:0] Green,
  output logic [N_PH-1:0] Yellow,
  output logic [N_PH-1:0] Red,
  output logic            Walk,
  output logic            WR_Reset,
  output logic [PW-1:0]   Phase
);

  localparam logic [PW-1:0] LAST_PH = PW'(N_PH - 1);

  state_e          state_q, state_d;
  logic [PW-1:0]   phase_q, phase_d;
  logic            ext_q, ext_d;
  logic            pending_q, pending_d;
  logic            wr_reset_q, enter_walk;
  logic            restart_q, restart_d;

  logic            tmr_load;
  logic [TW-1:0]   tmr_value;
  logic [TW-1:0]   tmr_count;
  logic            tmr_expired;

  logic [TW-1:0]   dur_q [4];
  logic [N_PH-1:0] lamp_mask;

  // The controller only needs the expiry flag; the raw count is for observation.
  logic            unused_count;
  assign unused_count = ^tmr_count;

  // NOTE: the duration registers are reset because their power-up contents
  // (the T_* defaults) are functional, not scratch storage.
  always_ff @(posedge clk or negedge Reset_n) begin
    if (!Reset_n) begin
      dur_q[SEL_BASE] <= TW'(T_BASE);
      dur_q[SEL_EXT]  <= TW'(T_EXT);
      dur_q[SEL_YEL]  <= TW'(T_YEL);
      dur_q[SEL_WALK] <= TW'(T_WALK);
    end else if (Prog_Sync) begin
      dur_q[Prog_Sel] <= Prog_Val;
    end
  end

  traffic_interval_timer #(.TW(TW)) u_timer (
    .clk     (clk),
    .Reset_n (Reset_n),
    .load    (tmr_load),
    .value   (tmr_value),
    .Tick    (Tick),
    .count   (tmr_count),
    .expired (tmr_expired)
  );

  always_ff @(posedge clk or negedge Reset_n) begin
    if (!Reset_n) begin
      state_q    <= ST_ALLRED;
      phase_q    <= '0;
      ext_q      <= 1'b0;
      pending_q  <= 1'b0;
      wr_reset_q <= 1'b0;
      restart_q  <= 1'b1;
    end else begin
      state_q    <= state_d;
      phase_q    <= phase_d;
      ext_q      <= ext_d;
      pending_q  <= pending_d;
      wr_reset_q <= enter_walk;
      restart_q  <= restart_d;
    end
  end

  // NOTE: every signal driven here gets a default first, so no path through
  // the case tree can infer a latch.
  always_comb begin
    state_d   = state_q;
    phase_d   = phase_q;
    ext_d     = ext_q;
    restart_d = restart_q;
    tmr_load  = 1'b0;
    tmr_value = TW'(1);

    if (Prog_Sync) begin
      state_d   = ST_ALLRED;
      phase_d   = '0;
      ext_d     = 1'b0;
      restart_d = 1'b1;
      tmr_load  = 1'b1;
    end else if (tmr_expired) begin
      tmr_load = 1'b1;
      unique case (state_q)
        ST_GREEN: begin
          if (Sensor_Sync[phase_q] && !ext_q) begin
            ext_d     = 1'b1;
            tmr_value = dur_q[SEL_EXT];
          end else begin
            state_d   = ST_YELLOW;
            tmr_value = dur_q[SEL_YEL];
          end
        end
        ST_YELLOW: state_d = ST_ALLRED;
        ST_ALLRED: begin
          // After a reset or programming restart, the first green is phase 0
          // itself rather than the phase after it.
          restart_d = 1'b0;
          if (!restart_q && pending_q && (phase_q == LAST_PH)) begin
            state_d   = ST_WALK;
            tmr_value = dur_q[SEL_WALK];
          end else begin
            if (!restart_q) begin
              phase_d = (phase_q == LAST_PH) ? '0 : phase_q + PW'(1);
            end
            state_d   = ST_GREEN;
            ext_d     = 1'b0;
            tmr_value = dur_q[SEL_BASE];
          end
        end
        ST_WALK: begin
          phase_d   = '0;
          state_d   = ST_GREEN;
          ext_d     = 1'b0;
          tmr_value = dur_q[SEL_BASE];
        end
        default: ;
      endcase
    end

    // A request seen during the first walk cycle is the one being served.
    enter_walk = (state_d == ST_WALK) && (state_q != ST_WALK);
    pending_d  = enter_walk ? 1'b0 : (pending_q | (WR & ~wr_reset_q));
  end

  always_comb begin
    lamp_mask = N_PH'(1) << phase_q;
    Green     = '0;
    Yellow    = '0;
    Walk      = 1'b0;
    unique case (state_q)
      ST_GREEN:  Green  = lamp_mask;
      ST_YELLOW: Yellow = lamp_mask;
      ST_WALK:   Walk   = 1'b1;
      default:   ;
    endcase
    Red      = ~(Green | Yellow);
    WR_Reset = wr_reset_q;
    Phase    = phase_q;
  end

endmodule

// File: tb/tb_traffic_phase_ctrl.sv
// Self-checking bench: a 2-phase and a 4-phase controller run against an
// interval-level behavioural model, with directed scenarios and random traffic.
module tb_traffic_phase_ctrl;

  localparam int M_ALLRED = 0;
  localparam int M_GREEN  = 1;
  localparam int M_YELLOW = 2;
  localparam int M_WALK   = 3;

  logic       clk = 1'b0;
  logic       Reset_n;
  logic       tick_a, tick_b;
  logic [1:0] sensor2;
  logic [3:0] sensor4;
  logic       WR, Prog_Sync;
  logic [1:0] Prog_Sel;
  logic [7:0] Prog_Val;

  logic [1:0] g2, y2, r2;
  logic       w2, wrr2;
  logic [0:0] p2;
  logic [3:0] g4, y4, r4;
  logic       w4, wrr4;
  logic [1:0] p4;

  always #5 clk = ~clk;

  traffic_phase_ctrl #(.N_PH(2)) dut2 (
    .clk(clk), .Reset_n(Reset_n), .Tick(tick_a), .Sensor_Sync(sensor2), .WR(WR),
    .Prog_Sync(Prog_Sync), .Prog_Sel(Prog_Sel), .Prog_Val(Prog_Val),
    .Green(g2), .Yellow(y2), .Red(r2), .Walk(w2), .WR_Reset(wrr2), .Phase(p2)
  );

  traffic_phase_ctrl #(.N_PH(4)) dut4 (
    .clk(clk), .Reset_n(Reset_n), .Tick(tick_b), .Sensor_Sync(sensor4), .WR(WR),
    .Prog_Sync(Prog_Sync), .Prog_Sel(Prog_Sel), .Prog_Val(Prog_Val),
    .Green(g4), .Yellow(y4), .Red(r4), .Walk(w4), .WR_Reset(wrr4), .Phase(p4)
  );

  // Behavioural model: index 0 mirrors the 2-phase DUT, index 1 the 4-phase one.
  int st[2], ph[2], rem[2];
  bit ext[2], pend[2], fw[2], rs[2];
  int dur[2][4];

  int n_cmp = 0;
  int n_bad = 0;
  int cyc = 0;
  bit rand_mode = 0;
  int wrr_pulses = 0;

  bit prev_g4 = 0;
  int len4 = 0;
  int ph_q[$];
  int len_q[$];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  function automatic int eff(input int d);
    return (d == 0) ? 1 : d;
  endfunction

  task automatic model_reset(input int k);
    st[k] = M_ALLRED; ph[k] = 0; rem[k] = 1;
    ext[k] = 0; pend[k] = 0; fw[k] = 0; rs[k] = 1;
    dur[k][0] = 6; dur[k][1] = 3; dur[k][2] = 2; dur[k][3] = 4;
  endtask

  task automatic step(input int k);
    int nph;
    bit tk, sens, wr_seen, enter_walk;
    nph = (k == 0) ? 2 : 4;
    tk = (k == 0) ? tick_a : tick_b;
    sens = (k == 0) ? sensor2[ph[0]] : sensor4[ph[1]];
    wr_seen = WR && !fw[k];
    enter_walk = 0;
    if (Prog_Sync) begin
      dur[k][Prog_Sel] = Prog_Val;
      st[k] = M_ALLRED; ph[k] = 0; rem[k] = 1; ext[k] = 0; rs[k] = 1;
    end else if (tk) begin
      if (rem[k] > 1) begin
        rem[k]--;
      end else begin
        case (st[k])
          M_GREEN:
            if (sens && !ext[k]) begin
              ext[k] = 1; rem[k] = eff(dur[k][1]);
            end else begin
              st[k] = M_YELLOW; rem[k] = eff(dur[k][2]);
            end
          M_YELLOW: begin
            st[k] = M_ALLRED; rem[k] = 1;
          end
          M_ALLRED: begin
            if (!rs[k] && pend[k] && ph[k] == nph - 1) begin
              st[k] = M_WALK; rem[k] = eff(dur[k][3]); enter_walk = 1;
            end else begin
              if (!rs[k]) ph[k] = (ph[k] + 1) % nph;
              st[k] = M_GREEN; ext[k] = 0; rem[k] = eff(dur[k][0]);
            end
            rs[k] = 0;
          end
          default: begin
            ph[k] = 0; st[k] = M_GREEN; ext[k] = 0; rem[k] = eff(dur[k][0]);
          end
        endcase
      end
    end
    pend[k] = enter_walk ? 1'b0 : (pend[k] | wr_seen);
    fw[k] = enter_walk;
  endtask

  // Packs the expected lamps as {Green, Yellow, Red, Walk, WR_Reset, Phase}.
  function automatic logic [31:0] exp_pack(input int k);
    int nph, pw, g, y, r;
    nph = (k == 0) ? 2 : 4;
    pw = (k == 0) ? 1 : 2;
    g = (st[k] == M_GREEN) ? (1 << ph[k]) : 0;
    y = (st[k] == M_YELLOW) ? (1 << ph[k]) : 0;
    r = ((1 << nph) - 1) & ~(g | y);
    return 32'((g << (2 * nph + 2 + pw)) | (y << (nph + 2 + pw)) | (r << (2 + pw)) |
               ((st[k] == M_WALK) ? (1 << (1 + pw)) : 0) | (int'(fw[k]) << pw) | ph[k]);
  endfunction

  function automatic logic [31:0] act2();
    return {23'd0, g2, y2, r2, w2, wrr2, p2};
  endfunction

  function automatic logic [31:0] act4();
    return {16'd0, g4, y4, r4, w4, wrr4, p4};
  endfunction

  function automatic int obs_state();
    if (|g2) return M_GREEN;
    if (|y2) return M_YELLOW;
    if (w2) return M_WALK;
    return M_ALLRED;
  endfunction

  task automatic cycle();
    @(posedge clk);
    for (int k = 0; k < 2; k++) begin
      if (!Reset_n) model_reset(k);
      else step(k);
    end
    @(negedge clk);
    check("dut2_outputs", act2(), exp_pack(0));
    check("dut4_outputs", act4(), exp_pack(1));
    if (wrr2) wrr_pulses++;
    if ((|g4) && !prev_g4) begin
      ph_q.push_back(int'(p4));
      len4 = 1;
    end else if (|g4) begin
      len4++;
    end else if (prev_g4) begin
      len_q.push_back(len4);
    end
    prev_g4 = |g4;
    cyc++;
    if (!rand_mode) begin
      tick_a = 1'b1;
      tick_b = (cyc % 3 == 0);
    end
  endtask

  task automatic measure(input int s, output int n);
    n = 0;
    while (obs_state() == s && n < 100) begin
      n++;
      cycle();
    end
  endtask

  initial begin
    int n;
    Reset_n = 1'b0; tick_a = 1'b1; tick_b = 1'b0;
    sensor2 = '0; sensor4 = '0; WR = 1'b0;
    Prog_Sync = 1'b0; Prog_Sel = '0; Prog_Val = '0;
    model_reset(0); model_reset(1);

    // Reset state, with WR asserted to show it is ignored.
    @(negedge clk);
    WR = 1'b1;
    repeat (3) cycle();
    check("reset_state", act2(), 32'h18);
    WR = 1'b0;
    Reset_n = 1'b1;
    cycle();
    check("first_green_p0", act2(), 32'h90);

    // Basic cycle timing.
    measure(M_GREEN, n);  check("p0_green_len", n, 6);
    measure(M_YELLOW, n); check("p0_yellow_len", n, 2);
    measure(M_ALLRED, n); check("p0_allred_len", n, 1);
    check("p1_green_start", act2(), 32'h109);
    measure(M_GREEN, n);  check("p1_green_len", n, 6);
    measure(M_YELLOW, n);
    measure(M_ALLRED, n);

    // One extension only while the sensor is held.
    sensor2 = 2'b01;
    measure(M_GREEN, n);  check("p0_extended_green_len", n, 9);
    sensor2 = 2'b00;
    measure(M_YELLOW, n);
    measure(M_ALLRED, n);
    measure(M_GREEN, n);
    measure(M_YELLOW, n);
    measure(M_ALLRED, n);

    // Walk request during phase 0 green.
    WR = 1'b1;
    cycle();
    WR = 1'b0;
    wrr_pulses = 0;
    measure(M_GREEN, n);
    measure(M_YELLOW, n);
    measure(M_ALLRED, n);
    measure(M_GREEN, n);  check("p1_green_before_walk", n, 6);
    measure(M_YELLOW, n);
    measure(M_ALLRED, n); check("p1_allred_before_walk", n, 1);
    check("walk_entered", obs_state(), M_WALK);
    check("wr_reset_first_cycle", wrr2, 1'b1);
    measure(M_WALK, n);   check("walk_len", n, 4);
    check("wr_reset_pulses", wrr_pulses, 1);
    check("green_p0_after_walk", act2(), 32'h90);

    // Programming yellow to 0 during green.
    Prog_Sync = 1'b1; Prog_Sel = 2'd2; Prog_Val = 8'd0;
    cycle();
    Prog_Sync = 1'b0;
    check("prog_forces_allred_p0", act2(), 32'h18);
    measure(M_ALLRED, n); check("prog_allred_len", n, 1);
    check("prog_green_p0", act2(), 32'h90);
    measure(M_GREEN, n);  check("green_len_after_prog", n, 6);
    measure(M_YELLOW, n); check("yellow_len_zero_prog", n, 1);

    // Asynchronous reset in the middle of a yellow.
    measure(M_ALLRED, n);
    measure(M_GREEN, n);
    check("in_yellow_before_reset", obs_state(), M_YELLOW);
    Reset_n = 1'b0;
    #1;
    model_reset(0); model_reset(1);
    check("async_reset_red", act2(), 32'h18);
    check("async_reset_dut4", act4(), exp_pack(1));
    WR = 1'b1;
    repeat (2) cycle();
    WR = 1'b0;
    Reset_n = 1'b1;
    ph_q.delete(); len_q.delete(); prev_g4 = 0; len4 = 0;
    cycle();
    check("green_p0_after_reset", act2(), 32'h90);

    // Four-phase controller with a tick every third cycle.
    repeat (130) cycle();
    check("dut4_green_count", 32'(ph_q.size() >= 5), 1);
    for (int i = 0; i < 5; i++)
      if (i < ph_q.size()) check("dut4_phase_order", ph_q[i], i % 4);
    for (int i = 0; i < 4; i++)
      if (i < len_q.size()) check("dut4_green_len", len_q[i], 18);

    // Random traffic.
    rand_mode = 1;
    for (int i = 0; i < 3000; i++) begin
      tick_a    = ($urandom % 3) != 0;
      tick_b    = $urandom % 2;
      sensor2   = 2'($urandom);
      sensor4   = 4'($urandom);
      WR        = ($urandom % 16) == 0;
      Prog_Sync = ($urandom % 97) == 0;
      Prog_Sel  = 2'($urandom);
      Prog_Val  = 8'($urandom % 6);
      Reset_n   = ($urandom % 500) != 0;
      cycle();
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
